first_stage_mac_accumulator: RTL and testbench
==============================================

Name: first_stage_mac_accumulator

Overview:
- Sits directly downstream of the first-stage quadrant address generator.
- Consumes the weight and pixel words returned by the filter and input memories, one element per issued address pair. Multiply-accumulates each VECTOR_LEN-element vector into one partial sum.
- Optional ReLU on each finished sum; results are buffered in a small FIFO with a valid/ready output.
- Drives en back to the address generator so issue stalls when result space runs out.

Parameters:
- DATA_W, 8: width of filter_data and input_data.
- ACC_W, 20: accumulator and result width, signed.
- VECTOR_LEN, 16: elements per vector (matches the 4-bit element index).
- MEM_LATENCY, 1: cycles from operand_valid to read data valid; legal range 1..4.
- FIFO_DEPTH, 4: result buffer entries, power of two.
- RELU, 1: 1 = clamp negative results to 0 on push.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft flush, active high.
- operand_valid  in  1  address pair issued this cycle (filter_address_ready & input_address_ready).
- last_element  in  1  qualifies operand_valid; marks the final element of a vector.
- quadrant  in  2  quadrant tag, sampled with operand_valid.
- filter_data  in  DATA_W  signed weight, valid MEM_LATENCY cycles after operand_valid.
- input_data  in  DATA_W  unsigned pixel, same timing as filter_data.
- en  out  1  issue enable to the address generator.
- result_data  out  ACC_W  signed accumulated sum.
- result_quadrant  out  2  quadrant tag of result_data.
- result_valid  out  1  FIFO head valid.
- result_ready  in  1  consumer accepts the head.
- overflow  out  1  sticky saturation flag.

Behaviour:
- Reset (clear_n low, async): all pipeline valids, accumulator, FIFO pointers and count cleared. Outputs: en=1, result_valid=0, result_data=0, result_quadrant=0, overflow=0.
- clear=1: same effect as reset, synchronous; it takes priority over every other event in that cycle.
- operand_valid is sampled only when en=1; it is ignored when en=0.
- Align stage: operand_valid, last_element and quadrant pass through a MEM_LATENCY-deep shift register so they line up with the returned data.
- Multiply stage (1 cycle, registered): product = signed(filter_data) * signed({1'b0,input_data}), width 2*DATA_W+1.
- Accumulate stage (1 cycle):
  - acc_next = acc + sign-extended product, saturated to the signed ACC_W range.
  - Any saturation sets overflow; it stays set until reset or clear.
- On a valid element tagged last: push f(acc_next) with its quadrant into the FIFO, where f is ReLU if RELU=1, else identity. Accumulator returns to 0 in the same cycle.
- Total latency: operand_valid of the last element to result_valid = MEM_LATENCY+3 cycles, assuming the FIFO was empty.
- Gaps between elements: the accumulator holds its value. No timeout.
- Vector length is not counted internally; last_element alone ends a vector. A new vector's first element may follow the previous last_element on the next cycle.
- Credit rule: reserved = fifo_count + (number of last flags in the align/mult/acc stages).
  - en = (reserved < FIFO_DEPTH), registered.
  - A push is therefore never refused; no FIFO overflow is possible.
  - en may fall mid-vector; the partial sum is held and the vector resumes when en returns.
- FIFO:
  - Head is shown on result_data and result_quadrant; pop when result_valid & result_ready.
  - Push and pop in the same cycle are allowed when full or empty. When empty, a simultaneous push/pop does not bypass: result_valid rises the next cycle.
  - result_data and result_quadrant are 0 when the FIFO is empty.
- Order: results leave in vector completion order.

Decomposition:
- Package first_stage_pkg holds DATA_W, ACC_W, VECTOR_LEN, FIFO_DEPTH defaults, the quadrant_t (2-bit) typedef, and the saturation bounds ACC_MAX and ACC_MIN.
- One sub-module, first_stage_result_fifo: synchronous FIFO with count output and data width ACC_W+2. The MAC pipeline and credit logic stay in the top.

Test Plan:
- 16 elements, weight 1, pixel 1, last on the 16th -> one result 16, quadrant as tagged; result_valid appears 4 cycles after the last operand_valid.
- RELU=1, weight -1, pixel 255 ×16 -> 0. With RELU=0 -> -4080. overflow stays 0 in both cases.
- ACC_W=16, weight -128, pixel 255 ×16 -> result -32768, overflow=1. A following vector of 1×1 ×16 -> 16, with overflow still 1.
- result_ready=0, five back-to-back 16-element vectors -> en falls after the 4th vector reserves. No loss; operands offered while en=0 are ignored. Raise result_ready -> results pop in order with the correct quadrant tags, and en returns to 1.
- Assert clear_n low for 2 cycles at element 7 of a vector -> all outputs return to their reset values. The next full vector yields only its own sum.
- clear pulse in the same cycle as the last element's accumulate -> no push, FIFO empty, acc=0 on the next cycle.

Source files
------------

// File: rtl/first_stage_mac_accumulator_pkg.sv
// Shared defaults and types for the first-stage MAC accumulator slice.
package first_stage_pkg;

   localparam int DATA_W     = 8;
   localparam int ACC_W      = 20;
   localparam int VECTOR_LEN = 16;
   localparam int FIFO_DEPTH = 4;

   typedef logic [1:0] quadrant_t;

   // Saturation bounds for the default accumulator width.
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/first_stage_mac_accumulator_if.sv
// Operand/result bus between the address generator, memories and the MAC accumulator.
interface first_stage_mac_accumulator_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
);
   import first_stage_pkg::*;

   logic              operand_valid;
   logic              last_element;
   quadrant_t         quadrant;
   logic [DATA_W-1:0] filter_data;
   logic [DATA_W-1:0] input_data;
   logic              en;
   logic [ACC_W-1:0]  result_data;
   quadrant_t         result_quadrant;
   logic              result_valid;
   logic              result_ready;
   logic              overflow;

   modport master (
      output operand_valid, last_element, quadrant, filter_data, input_data, result_ready,
      input  en, result_data, result_quadrant, result_valid, overflow
   );

   modport slave (
      input  operand_valid, last_element, quadrant, filter_data, input_data, result_ready,
      output en, result_data, result_quadrant, result_valid, overflow
   );

endinterface

// File: rtl/first_stage_result_fifo.sv
// Small synchronous result FIFO; head is zero while empty.
module first_stage_result_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           clear_n,
   input  logic                           clear,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head_data,
   output logic                           head_valid,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   import first_stage_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // Pop only a real head; push when there is room or the head leaves this cycle.
   always_comb begin
      do_pop     = pop & (count != '0);
      do_push    = push & ((count != CW'(DEPTH)) | do_pop);
      head_valid = (count != '0);
      head_data  = head_valid ? mem[rd_ptr] : '0;
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array; contents are don't-care until the count covers them.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/first_stage_mac_accumulator.sv
// Multiply-accumulates returned weight/pixel pairs into per-vector partial sums,
// buffers finished sums and throttles address issue through a credit count.
module first_stage_mac_accumulator #(
   parameter int DATA_W      = first_stage_pkg::DATA_W,
   parameter int ACC_W       = first_stage_pkg::ACC_W,
   parameter int VECTOR_LEN  = first_stage_pkg::VECTOR_LEN,
   parameter int MEM_LATENCY = 1,
   parameter int FIFO_DEPTH  = first_stage_pkg::FIFO_DEPTH,
   parameter int RELU        = 1
) (
   input  logic                         clock,
   input  logic                         clear_n,
   input  logic                         clear,
   first_stage_mac_accumulator_if.slave bus
);
   import first_stage_pkg::*;

   localparam int PROD_W = 2*DATA_W + 1;
   localparam int RES_W  = ACC_W + 2;
   localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
   localparam int RSV_W  = $clog2(FIFO_DEPTH + MEM_LATENCY + 4) + 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
      $error("MEM_LATENCY must be 1..4");
   end
   if (ACC_W < 2*DATA_W || VECTOR_LEN < 1) begin : g_bad_width
      $error("ACC_W must hold one product and VECTOR_LEN must be positive");
   end

   // align stage
   logic [MEM_LATENCY-1:0] al_vld, al_last;
   quadrant_t              al_quad [MEM_LATENCY];
   // multiply stage
   logic                       m_vld, m_last;
   quadrant_t                  m_quad;
   logic signed [PROD_W-1:0]   prod;
   // accumulate stage
   logic signed [ACC_W-1:0]    acc, acc_next, relu_out, res_data;
   logic signed [ACC_W:0]      sum_wide;
   logic                       sat_hit, res_vld, overflow_r;
   quadrant_t                  res_quad;
   // credit / fifo
   logic                       en_r, take;
   logic [RSV_W-1:0]           reserved;
   logic [CNT_W-1:0]           fifo_count;
   logic [RES_W-1:0]           head;
   logic                       head_valid;

   assign take = bus.operand_valid & en_r;

   // Delay issue tags so they line up with the data returned by the memories.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         al_vld  <= '0;
         al_last <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) al_quad[i] <= '0;
      end else if (clear) begin
         al_vld  <= '0;
         al_last <= '0;
      end else begin
         al_vld[0]  <= take;
         al_last[0] <= take & bus.last_element;
         al_quad[0] <= bus.quadrant;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            al_vld[i]  <= al_vld[i-1];
            al_last[i] <= al_last[i-1];
            al_quad[i] <= al_quad[i-1];
         end
      end
   end

   // Register the signed-weight by unsigned-pixel product.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_vld  <= 1'b0;
         m_last <= 1'b0;
         m_quad <= '0;
         prod   <= '0;
      end else if (clear) begin
         m_vld  <= 1'b0;
         m_last <= 1'b0;
      end else begin
         m_vld  <= al_vld[MEM_LATENCY-1];
         m_last <= al_last[MEM_LATENCY-1];
         m_quad <= al_quad[MEM_LATENCY-1];
         prod   <= $signed(bus.filter_data) * $signed({1'b0, bus.input_data});
      end
   end

   // One guard bit catches wrap; clamp to the signed range and apply optional ReLU.
   always_comb begin
      sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
      sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      acc_next = sum_wide[ACC_W-1:0];
      if (sat_hit) acc_next = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
      relu_out = ((RELU != 0) && acc_next[ACC_W-1]) ? '0 : acc_next;
   end

   // Accumulate; a last element stages its sum for the FIFO and restarts the accumulator.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         acc        <= '0;
         overflow_r <= 1'b0;
         res_vld    <= 1'b0;
         res_data   <= '0;
         res_quad   <= '0;
      end else if (clear) begin
         acc        <= '0;
         overflow_r <= 1'b0;
         res_vld    <= 1'b0;
      end else begin
         res_vld <= m_vld & m_last;
         if (m_vld) begin
            acc        <= m_last ? '0 : acc_next;
            overflow_r <= overflow_r | sat_hit;
            res_data   <= relu_out;
            res_quad   <= m_quad;
         end
      end
   end

   // Results owed = FIFO entries + last flags in flight, including one being issued now.
   always_comb begin
      reserved = RSV_W'(fifo_count);
      for (int i = 0; i < MEM_LATENCY; i++) reserved = reserved + RSV_W'(al_last[i]);
      reserved = reserved + RSV_W'(m_last) + RSV_W'(res_vld)
               + RSV_W'(take & bus.last_element);
   end

   // Issue enable drops once every FIFO slot is spoken for, so pushes are never refused.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)   en_r <= 1'b1;
      else if (clear) en_r <= 1'b1;
      else            en_r <= (reserved < RSV_W'(FIFO_DEPTH));
   end

   first_stage_result_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .clear_n    (clear_n),
      .clear      (clear),
      .push       (res_vld),
      .push_data  ({res_quad, res_data}),
      .pop        (head_valid & bus.result_ready),
      .head_data  (head),
      .head_valid (head_valid),
      .count      (fifo_count)
   );

   assign bus.en              = en_r;
   assign bus.overflow        = overflow_r;
   assign bus.result_valid    = head_valid;
   assign bus.result_data     = head[ACC_W-1:0];
   assign bus.result_quadrant = head[ACC_W+1:ACC_W];

endmodule

// File: tb/tb_first_stage_mac_accumulator.sv
// Scoreboard bench: three configurations (ReLU/20b, identity/20b, identity/16b) see identical stimulus.
module tb_first_stage_mac_accumulator;
   import first_stage_pkg::*;

   typedef struct {
      longint d;
      int     q;
   } exp_t;

   logic      clock = 1'b0;
   logic      clear_n, clear, ov, le, rr;
   quadrant_t qd;
   int        fw, px;
   logic [7:0] fd, pd;
   int        n_chk = 0, n_err = 0;
   exp_t      sb_a[$], sb_b[$], sb_c[$];
   longint    macc [3];

   first_stage_mac_accumulator_if #(.DATA_W(8), .ACC_W(20)) if_a ();
   first_stage_mac_accumulator_if #(.DATA_W(8), .ACC_W(20)) if_b ();
   first_stage_mac_accumulator_if #(.DATA_W(8), .ACC_W(16)) if_c ();

   assign if_a.operand_valid = ov;  assign if_b.operand_valid = ov;  assign if_c.operand_valid = ov;
   assign if_a.last_element  = le;  assign if_b.last_element  = le;  assign if_c.last_element  = le;
   assign if_a.quadrant      = qd;  assign if_b.quadrant      = qd;  assign if_c.quadrant      = qd;
   assign if_a.filter_data   = fd;  assign if_b.filter_data   = fd;  assign if_c.filter_data   = fd;
   assign if_a.input_data    = pd;  assign if_b.input_data    = pd;  assign if_c.input_data    = pd;
   assign if_a.result_ready  = rr;  assign if_b.result_ready  = rr;  assign if_c.result_ready  = rr;

   first_stage_mac_accumulator #(.DATA_W(8), .ACC_W(20), .VECTOR_LEN(16), .MEM_LATENCY(1),
      .FIFO_DEPTH(4), .RELU(1)) dut_a (.clock(clock), .clear_n(clear_n), .clear(clear), .bus(if_a.slave));
   first_stage_mac_accumulator #(.DATA_W(8), .ACC_W(20), .VECTOR_LEN(16), .MEM_LATENCY(1),
      .FIFO_DEPTH(4), .RELU(0)) dut_b (.clock(clock), .clear_n(clear_n), .clear(clear), .bus(if_b.slave));
   first_stage_mac_accumulator #(.DATA_W(8), .ACC_W(16), .VECTOR_LEN(16), .MEM_LATENCY(1),
      .FIFO_DEPTH(4), .RELU(0)) dut_c (.clock(clock), .clear_n(clear_n), .clear(clear), .bus(if_c.slave));

   always #5 clock = ~clock;

   // one-cycle memory: data for an address shows up the cycle after it is issued
   always @(posedge clock) begin
      fd <= 8'(fw);
      pd <= 8'(px);
   end

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << (w-1)) - 1;
      if (v > mx) return mx;
      if (v < -mx-1) return -mx-1;
      return v;
   endfunction

   task automatic model_elem(input int w, input int p, input int q, input bit last, input bit keep);
      exp_t e;
      macc[0] = sat(macc[0] + longint'(w*p), 20);
      macc[1] = sat(macc[1] + longint'(w*p), 20);
      macc[2] = sat(macc[2] + longint'(w*p), 16);
      if (last) begin
         if (keep) begin
            e.q = q;
            e.d = (macc[0] < 0) ? 0 : macc[0]; sb_a.push_back(e);
            e.d = macc[1];                     sb_b.push_back(e);
            e.d = macc[2];                     sb_c.push_back(e);
         end
         macc = '{0, 0, 0};
      end
   endtask

   // offers each element until accepted (en high); entry/exit phase is #1 after a rising edge
   task automatic send_vec(input int w, input int p, input int q, input int n,
                           input bit with_last, input bit keep);
      for (int i = 0; i < n; i++) begin
         bit got;
         int tries;
         got = 1'b0;
         tries = 0;
         ov = 1'b1; fw = w; px = p; qd = 2'(q);
         le = with_last && (i == n-1);
         while (!got) begin
            got = if_a.en;
            @(posedge clock); #1;
            if (!got) begin
               tries++;
               if (tries > 2000) begin
                  chk("accept_timeout", 0, 1);
                  ov = 1'b0; le = 1'b0;
                  return;
               end
            end
         end
         model_elem(w, p, q, (with_last && (i == n-1)), keep);
      end
      ov = 1'b0; le = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 400 && (sb_a.size() + sb_b.size() + sb_c.size()) != 0; k++)
         @(negedge clock);
      chk({tag, "_drain"}, sb_a.size() + sb_b.size() + sb_c.size(), 0);
      @(posedge clock); #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_en"},    if_a.en, 1);
      chk({tag, "_rv_a"},  if_a.result_valid, 0);
      chk({tag, "_rv_c"},  if_c.result_valid, 0);
      chk({tag, "_data"},  if_a.result_data, 0);
      chk({tag, "_quad"},  if_a.result_quadrant, 0);
      chk({tag, "_ovf_c"}, if_c.overflow, 0);
   endtask

   // result monitors: pop the scoreboard whenever a DUT head is accepted
   always @(negedge clock) begin
      exp_t e;
      if (clear_n && !clear && rr && if_a.result_valid) begin
         if (sb_a.size() == 0) chk("a_extra", 1, 0);
         else begin
            e = sb_a.pop_front();
            chk("a_data", longint'($signed(if_a.result_data)), e.d);
            chk("a_quad", if_a.result_quadrant, e.q);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (clear_n && !clear && rr && if_b.result_valid) begin
         if (sb_b.size() == 0) chk("b_extra", 1, 0);
         else begin
            e = sb_b.pop_front();
            chk("b_data", longint'($signed(if_b.result_data)), e.d);
            chk("b_quad", if_b.result_quadrant, e.q);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (clear_n && !clear && rr && if_c.result_valid) begin
         if (sb_c.size() == 0) chk("c_extra", 1, 0);
         else begin
            e = sb_c.pop_front();
            chk("c_data", longint'($signed(if_c.result_data)), e.d);
            chk("c_quad", if_c.result_quadrant, e.q);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_n = 1'b0; clear = 1'b0; ov = 1'b0; le = 1'b0; qd = '0;
      fw = 0; px = 0; rr = 1'b1; macc = '{0, 0, 0};
      repeat (3) @(posedge clock);
      #1;
      check_reset("por");
      clear_n = 1'b1;
      @(posedge clock); #1;

      // basic vector and latency from last operand_valid to result_valid
      send_vec(1, 1, 2, 16, 1'b1, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         chk($sformatf("lat_rv_%0d", k), if_a.result_valid, (k == 4) ? 1 : 0);
      end
      wait_drain("t1");

      // negative sums: ReLU clamps, identity keeps -4080, no saturation
      send_vec(-1, 255, 1, 16, 1'b1, 1'b1);
      wait_drain("t2");
      chk("t2_ovf_a", if_a.overflow, 0);
      chk("t2_ovf_b", if_b.overflow, 0);
      chk("t2_ovf_c", if_c.overflow, 0);

      // 16-bit config saturates at -32768; 20-bit configs do not
      send_vec(-128, 255, 3, 16, 1'b1, 1'b1);
      wait_drain("t3");
      chk("t3_ovf_b", if_b.overflow, 0);
      chk("t3_ovf_c", if_c.overflow, 1);

      // following vector is clean but the overflow flag is sticky
      send_vec(1, 1, 0, 16, 1'b1, 1'b1);
      wait_drain("t4");
      chk("t4_ovf_c", if_c.overflow, 1);

      // back-pressure: five vectors with the consumer stalled
      rr = 1'b0;
      fork
         begin
            for (int v = 0; v < 5; v++) send_vec(v+1, 2, v % 4, 16, 1'b1, 1'b1);
         end
         begin
            for (int k = 0; k < 400 && if_a.en; k++) @(negedge clock);
            chk("stall_en_fall", if_a.en, 0);
            chk("stall_vectors_reserved", sb_a.size(), 4);
            repeat (10) @(negedge clock);
            chk("stall_en_held", if_a.en, 0);
            chk("stall_head_valid", if_a.result_valid, 1);
            @(posedge clock); #1;
            rr = 1'b1;
         end
      join
      wait_drain("t5");
      chk("t5_en_back", if_a.en, 1);

      // async reset mid-vector
      send_vec(1, 1, 1, 7, 1'b0, 1'b1);
      clear_n = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      check_reset("rst_mid");
      clear_n = 1'b1;
      macc = '{0, 0, 0};
      @(posedge clock); #1;
      check_reset("rst_after");
      send_vec(2, 3, 2, 16, 1'b1, 1'b1);
      wait_drain("t6");

      // soft clear on the accumulate cycle of the last element suppresses the push
      send_vec(3, 2, 1, 16, 1'b1, 1'b0);
      @(posedge clock); #1;
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("clr_no_push", if_a.result_valid, 0);
      end
      chk("clr_en", if_a.en, 1);
      @(posedge clock); #1;
      send_vec(1, 2, 3, 16, 1'b1, 1'b1);
      wait_drain("t7");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
